// File: rtl/shift_sequencer.sv
// Sequencer that drives an external 32-bit shifter through LOAD then steps of up to 3 bits.
// Optional feature macro: SHIFT_SEQ_ERR_EN enables the registered illegal-op pulse on err.
module shift_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  amount,
    input  logic [31:0] d_in,
    input  logic [31:0] sh_q,
    output logic [2:0]  sh_op,
    output logic [1:0]  sh_shamt,
    output logic [31:0] sh_d_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_LOAD = 3'b001;
    localparam logic [2:0] CMD_LSL  = 3'b010;
    localparam logic [2:0] CMD_LSR  = 3'b011;
    localparam logic [2:0] CMD_ASR  = 3'b100;

    state_t      state_r, state_s;
    logic [4:0]  rem_r, rem_s;
    logic [1:0]  op_r;
    logic [31:0] operand_r;
    logic        done_r;
    logic [31:0] result_r;
    logic        accept_s;
    logic [1:0]  step_s;

    function automatic logic [2:0] map_op(input logic [1:0] o);
        case (o)
            2'b00:   map_op = CMD_LSL;
            2'b01:   map_op = CMD_LSR;
            2'b10:   map_op = CMD_ASR;
            default: map_op = CMD_NOP;
        endcase
    endfunction

    assign accept_s = (state_r == IDLE) && start && (op != 2'b11);
    assign busy     = (state_r != IDLE);
    assign done     = done_r;
    assign result   = result_r;

    // State and remaining-distance registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            rem_r   <= 5'd0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
        end
    end

    // Request capture; only written on an accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r      <= 2'b00;
            operand_r <= 32'h0000_0000;
        end else if (accept_s) begin
            op_r      <= op;
            operand_r <= d_in;
        end else begin
            op_r      <= op_r;
            operand_r <= operand_r;
        end
    end

    // Next-state and shifter command decode
    always_comb begin
        state_s  = state_r;
        rem_s    = rem_r;
        step_s   = 2'd0;
        sh_op    = CMD_NOP;
        sh_shamt = 2'd0;
        sh_d_in  = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = LOAD;
                    rem_s   = amount;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                sh_op   = CMD_LOAD;
                sh_d_in = operand_r;
                if (rem_r != 5'd0) begin
                    state_s = SHIFT;
                end else begin
                    state_s = DONE;
                end
            end
            SHIFT: begin
                // Step is clamped to the remaining distance, so rem cannot wrap
                step_s   = (rem_r >= 5'd3) ? 2'd3 : rem_r[1:0];
                sh_op    = map_op(op_r);
                sh_shamt = step_s;
                rem_s    = rem_r - {3'b000, step_s};
                if (rem_s == 5'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                rem_s   = 5'd0;
            end
        endcase
    end

    // Completion pulse and result capture from the shifter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r   <= 1'b0;
            result_r <= 32'h0000_0000;
        end else if (state_r == DONE) begin
            done_r   <= 1'b1;
            result_r <= sh_q;
        end else begin
            done_r   <= 1'b0;
            result_r <= result_r;
        end
    end

`ifdef SHIFT_SEQ_ERR_EN
    logic err_r;

    // One-cycle pulse for an illegal op sampled in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_r == IDLE) && start && (op == 2'b11);
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural shifter and arithmetic reference model.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  amount;
    logic [31:0] d_in;
    logic [31:0] sh_q;
    logic [2:0]  sh_op;
    logic [1:0]  sh_shamt;
    logic [31:0] sh_d_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

`ifdef SHIFT_SEQ_ERR_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    shift_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
        .d_in(d_in), .sh_q(sh_q), .sh_op(sh_op), .sh_shamt(sh_shamt),
        .sh_d_in(sh_d_in), .busy(busy), .done(done), .result(result), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached shifter: a plain register obeying the command bus
    always @(posedge clk) begin
        case (sh_op)
            3'b001:  sh_q <= sh_d_in;
            3'b010:  sh_q <= sh_q << sh_shamt;
            3'b011:  sh_q <= sh_q >> sh_shamt;
            3'b100:  sh_q <= $signed(sh_q) >>> sh_shamt;
            default: sh_q <= sh_q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [4:0] a,
                                               input logic [31:0] d);
        case (o)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            default: return $signed(d) >>> a;
        endcase
    endfunction

    // Called at a negedge with the DUT idle (or in its done cycle); returns at the done cycle.
    task automatic run_seq(input logic [1:0] o, input logic [4:0] a, input logic [31:0] d,
                           input bit stray);
        int rem;
        int step;
        logic [31:0] exp_cmd;
        start = 1'b1; op = o; amount = a; d_in = d;
        @(negedge clk);
        start = 1'b0;
        chk("load_op", 32'(sh_op), 32'd1);
        chk("load_d", sh_d_in, d);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_done", 32'(done), 32'd0);
        exp_cmd = 32'd2 + 32'(o);
        rem = int'(a);
        while (rem > 0) begin
            if (stray) begin
                start = 1'b1;
                op = 2'($urandom_range(0, 2));
                amount = 5'($urandom);
                d_in = $urandom;
            end
            @(negedge clk);
            step = (rem > 3) ? 3 : rem;
            chk("shift_op", 32'(sh_op), exp_cmd);
            chk("shift_amt", 32'(sh_shamt), 32'(step));
            chk("shift_done", 32'(done), 32'd0);
            rem -= step;
        end
        @(negedge clk);
        start = 1'b0;
        chk("donest_op", 32'(sh_op), 32'd0);
        chk("donest_amt", 32'(sh_shamt), 32'd0);
        chk("donest_d", sh_d_in, 32'd0);
        chk("donest_busy", 32'(busy), 32'd1);
        chk("donest_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("result", result, ref_result(o, a, d));
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [4:0]  r_amt;
        logic [31:0] held;
        reset = 1'b1; start = 1'b0; op = 2'b00; amount = 5'd0; d_in = 32'h0; sh_q = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_shop", 32'(sh_op), 32'd0);
        chk("rst_shamt", 32'(sh_shamt), 32'd0);
        chk("rst_shd", sh_d_in, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Abort in second SHIFT cycle of a 9-bit LSL
        start = 1'b1; op = 2'b00; amount = 5'd9; d_in = 32'h0000_0003;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_shop", 32'(sh_op), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done), 32'd0);
            chk("abort_result", result, 32'h0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        // Directed cases
        run_seq(2'b00, 5'd5, 32'h0000_0001, 1'b0);
        chk("lsl5_value", result, 32'h0000_0020);
        @(negedge clk);
        run_seq(2'b10, 5'd31, 32'h8000_0000, 1'b0);
        chk("asr31_value", result, 32'hFFFF_FFFF);
        @(negedge clk);
        run_seq(2'b01, 5'd0, 32'hF000_0000, 1'b0);
        chk("lsr0_value", result, 32'hF000_0000);
        @(negedge clk);
        run_seq(2'b00, 5'd7, 32'h1234_5679, 1'b1);
        held = result;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_done", 32'(done), 32'd0);
            chk("ignored_busy", 32'(busy), 32'd0);
            chk("result_hold", result, held);
        end

        // Illegal op
        start = 1'b1; op = 2'b11; amount = 5'd4; d_in = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), EXP_ERR);
        chk("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_clear", 32'(err), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);
        chk("err_result", result, held);

        // Randomized requests; no gap means the next start lands in the done cycle
        for (int n = 0; n < 40; n++) begin
            r_op = 2'($urandom_range(0, 2));
            r_amt = 5'($urandom);
            if (n % 10 == 0) r_amt = 5'd31;
            if (n % 10 == 1) r_amt = 5'd0;
            if (n % 10 == 2) r_amt = 5'(n % 4);
            run_seq(r_op, r_amt, $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rand_pulse_end", 32'(done), 32'd0);
            end
        end
        @(negedge clk);
        chk("final_done", 32'(done), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
